// File: rtl/regs.sv
// RV32I integer register file: x1-x31 storage, two combinational read ports,
// one execute write port and a low-priority debug req/ack access port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no debug access in flight
// WAIT  | debug write pending, blocked by a same-cycle execute write
// ACK   | debug access done, ack high until the request drops
module regs #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  reg1_raddr_i,
  output logic [31:0] reg1_rdata_o,
  input  logic [4:0]  reg2_raddr_i,
  output logic [31:0] reg2_rdata_o,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_wen_i,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_rdata_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dbg_state_t;

  dbg_state_t  state;
  logic [31:0] regs_q [1:31];
  logic        core_wr;
  logic        dbg_wr;

  function automatic logic [31:0] read_val(input logic [4:0] addr);
    if (addr == 5'd0)
      return 32'd0;
    if (BYPASS_EN && rd_wen_i && (rd_addr_i == addr))
      return rd_data_i;
    return regs_q[addr];
  endfunction

  assign reg1_rdata_o = read_val(reg1_raddr_i);
  assign reg2_rdata_o = read_val(reg2_raddr_i);

  // A core write to x0 is not a conflict, so it never blocks debug.
  assign core_wr = rd_wen_i && (rd_addr_i != 5'd0);

  assign dbg_wr = !core_wr && (dbg_addr_i != 5'd0) &&
                  (((state == IDLE) && dbg_req_i && dbg_we_i) || (state == WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= 32'd0;
    end else if (core_wr) begin
      regs_q[rd_addr_i] <= rd_data_i;
    end else if (dbg_wr) begin
      regs_q[dbg_addr_i] <= dbg_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dbg_ack_o   <= 1'b0;
      dbg_rdata_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg_req_i) begin
            if (!dbg_we_i) begin
              dbg_rdata_o <= read_val(dbg_addr_i);
              state       <= ACK;
              dbg_ack_o   <= 1'b1;
            end else if (core_wr) begin
              state <= WAIT;
            end else begin
              state     <= ACK;
              dbg_ack_o <= 1'b1;
            end
          end
        end
        // Request is deliberately ignored here: a started write always completes.
        WAIT: begin
          if (!core_wr) begin
            state     <= ACK;
            dbg_ack_o <= 1'b1;
          end
        end
        ACK: begin
          if (!dbg_req_i) begin
            state     <= IDLE;
            dbg_ack_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          dbg_ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/regs.md
# regs

Integer register file for the single-issue RV32I core. It holds x1–x31, with x0 hardwired to zero. Two combinational read ports feed the decode stage (op1/op2 sourcing). One write port is driven directly by the execute stage's `rd_addr_o`/`rd_data_o`/`rd_wen_o`. A low-priority debug access port with a 4-phase req/ack handshake lets the debug unit read or write any register without stalling the pipeline.

## Interface
Parameters:
- `BYPASS_EN`, default 1: 1 = a read port whose address matches the same-cycle execute write returns the write data; 0 = it returns the stored value.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `reg1_raddr_i` in 5: read port 1 address, from decode.
- `reg1_rdata_o` out 32: read port 1 data, combinational.
- `reg2_raddr_i` in 5: read port 2 address, from decode.
- `reg2_rdata_o` out 32: read port 2 data, combinational.
- `rd_addr_i` in 5: write address, from execute.
- `rd_data_i` in 32: write data, from execute.
- `rd_wen_i` in 1: write enable, from execute.
- `dbg_req_i` in 1: debug request; held high until `dbg_ack_o` is seen.
- `dbg_we_i` in 1: debug access type, 1 = write, 0 = read; stable while `dbg_req_i` is high.
- `dbg_addr_i` in 5: debug register address; stable while `dbg_req_i` is high.
- `dbg_wdata_i` in 32: debug write data; stable while `dbg_req_i` is high.
- `dbg_ack_o` out 1: debug acknowledge, registered.
- `dbg_rdata_o` out 32: debug read data, registered; holds its value until the next debug read.

## Operation
- **Storage:** 31 × 32-bit registers. x0 is not stored; every write to address 0, from execute or debug, is discarded.
- **Core write:** at a rising edge with `rd_wen_i`=1 and `rd_addr_i`≠0, `rd_data_i` is written to `rd_addr_i`.
- **Read port n (n = 1, 2):** the first matching rule applies.
  - address 0 → 0.
  - `BYPASS_EN`=1, `rd_wen_i`=1 and `rd_addr_i`==address → `rd_data_i`.
  - otherwise → stored value.
- **Core write conflict:** a "core write conflict" cycle is any cycle with `rd_wen_i`=1 and `rd_addr_i`≠0.
- **Debug FSM states:** IDLE, WAIT, ACK.
  - IDLE, `dbg_req_i`=0: stay in IDLE.
  - IDLE, `dbg_req_i`=1, `dbg_we_i`=0: at this edge, latch the read value into `dbg_rdata_o` (same rules as a read port, including bypass); go to ACK.
  - IDLE, `dbg_req_i`=1, `dbg_we_i`=1, no conflict: at this edge, write `dbg_wdata_i` to `dbg_addr_i` (dropped if the address is 0); go to ACK.
  - IDLE, `dbg_req_i`=1, `dbg_we_i`=1, conflict: go to WAIT. Execute always has priority; no write happens.
  - WAIT: at the first edge without a conflict, perform the write and go to ACK; otherwise stay in WAIT.
  - ACK: `dbg_ack_o`=1. When `dbg_req_i`=0, go to IDLE; `dbg_ack_o` falls at that edge.
- A debug write is never bypassed to the read ports. It is visible from the cycle after the commit edge.
- A debug read returns the value before any same-edge debug write, because the two never coincide.

## Timing
- **Reset values (while `rst`=0, immediately, no clock needed):**
  - x1–x31 = 0.
  - FSM = IDLE.
  - `dbg_ack_o` = 0.
  - `dbg_rdata_o` = 0.
  - Read ports show 0 through the combinational path.
- **Read latency:** 0 cycles, purely combinational from address and write inputs.
- **Core write latency:** data is stored at edge N and returned from storage in cycle N+1. Bypass covers cycle N.
- **Debug latency without conflict:** `dbg_req_i` is seen high before edge N; the operation happens at edge N; `dbg_ack_o`=1 from cycle N+1. The minimum handshake is 3 edges: operate, see req low, back to IDLE.
- **Debug latency with a conflict:** one extra cycle for each consecutive conflicting core write cycle. The wait is unbounded if execute writes every cycle.
- **Request deasserted while in WAIT:** protocol violation. The FSM completes the write anyway and acks.
- **Reset mid-handshake:** the FSM is forced to IDLE, ack drops asynchronously, and any pending debug write is lost. The requester must drop `dbg_req_i` and retry.

## Test plan
- **Reset:** assert `rst`=0 mid-run after writing x7=0x11111111. Required: `dbg_ack_o`=0 and `dbg_rdata_o`=0 asynchronously; after release, reads of all 32 addresses return 0.
- **Core write and bypass:** `rd_wen_i`=1, `rd_addr_i`=5, `rd_data_i`=0xDEADBEEF, with `reg2_raddr_i`=5 in the same cycle. Required:
  - `BYPASS_EN`=1: `reg2_rdata_o`=0xDEADBEEF in that cycle.
  - `BYPASS_EN`=0: `reg2_rdata_o`=0 in that cycle.
  - `reg1_raddr_i`=5 in the next cycle returns 0xDEADBEEF.
- **x0:** write x0=0x12345678 with `reg1_raddr_i`=0 in the same cycle. Required: `reg1_rdata_o`=0 in that cycle and afterwards. A debug read of x0 returns 0.
- **Debug write collision:** `dbg_req_i`=1, `dbg_we_i`=1, `dbg_addr_i`=10, `dbg_wdata_i`=0xA5A5A5A5, while execute writes x3 for 2 consecutive cycles. Required:
  - FSM in WAIT for 2 cycles.
  - Write commits at the first edge with `rd_wen_i`=0.
  - `dbg_ack_o` rises the cycle after the commit.
  - `reg1_raddr_i`=10 then returns 0xA5A5A5A5.
- **Debug read handshake:** with x5=0xDEADBEEF, issue a debug read of x5. Required:
  - `dbg_ack_o`=1 one cycle after the request, with `dbg_rdata_o`=0xDEADBEEF.
  - `dbg_ack_o` stays high while the request is held 4 more cycles.
  - `dbg_ack_o` falls one edge after `dbg_req_i` falls.
  - `dbg_rdata_o` still reads 0xDEADBEEF afterwards.
- **Debug read with bypass:** debug read of x6 in the same cycle execute writes x6=0x0BADF00D. Required: `dbg_rdata_o`=0x0BADF00D.
